// File: rtl/range_ctrl_pkg.sv
// Shared types for the range-finder session controller: FSM state encoding
// and the result record returned to the requesters.
package range_ctrl_pkg;

    localparam int RANGE_W = 10;
    localparam int REQ_N   = 2;
    localparam int ID_W    = $clog2(REQ_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WRAP  = 2'd3
    } state_t;

    // The controller's W and NREQ parameters are expected to match these widths.
    typedef struct packed {
        logic [RANGE_W-1:0] range;
        logic [ID_W-1:0]    id;
        logic               trunc;
        logic               err;
    } result_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/range_session_ctrl_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr, searching cyclically.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any
);

    always_comb begin
        int idx;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && req[idx[IDW-1:0]]) begin
                any   = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/range_session_ctrl.sv
// Time-shares one go/finish range-finder datapath among NREQ streaming
// requesters and returns each session's range through a one-entry result slot.
module range_session_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int W       = RANGE_W,
    parameter int NREQ    = REQ_N,
    parameter int MAX_LEN = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0][W-1:0]  req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [W-1:0]            res_range,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_trunc,
    output logic                    res_err,
    output logic [W-1:0]            rf_data,
    output logic                    rf_go,
    output logic                    rf_finish,
    input  logic [W-1:0]            rf_range,
    input  logic                    rf_error
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   range_q;
    logic [W-1:0]   hold_q;
    logic           trunc_q;
    logic           err_q;
    result_t        res_q;
    logic           res_valid_q;

    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           slot_free;
    logic           grant_fire;
    logic           grant_last;
    logic           cur_valid;
    logic           cur_last;
    logic [W-1:0]   cur_data;
    logic           finish_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_idx),
        .any   (grant_any)
    );

    // A held result may be consumed in the same cycle a new session is granted.
    assign slot_free  = !res_valid_q || res_ready;
    assign grant_fire = (state_q == IDLE) && slot_free && grant_any && !reset;
    assign grant_last = req_last[grant_idx];
    assign cur_valid  = req_valid[owner_q];
    assign cur_last   = req_last[owner_q];
    assign cur_data   = req_data[owner_q];
    assign finish_hit = cur_last || (cnt_q == LAST_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d = grant_last ? WRAP : RUN;
                end
            end
            RUN: begin
                if (cur_valid && finish_hit) begin
                    state_d = cur_last ? WRAP : DRAIN;
                end
            end
            DRAIN: begin
                if (cur_valid && cur_last) begin
                    state_d = WRAP;
                end
            end
            WRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rf_data falls back to the last sample handed over, so bubbles look like repeats.
    always_comb begin
        req_ready = '0;
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = hold_q;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        req_ready[grant_idx] = 1'b1;
                        if (!grant_last) begin
                            rf_go   = 1'b1;
                            rf_data = req_data[grant_idx];
                        end
                    end
                end
                RUN: begin
                    req_ready[owner_q] = 1'b1;
                    if (cur_valid) begin
                        rf_data   = cur_data;
                        rf_finish = finish_hit;
                    end
                end
                DRAIN: begin
                    req_ready[owner_q] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            range_q  <= '0;
            hold_q   <= '0;
            trunc_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        owner_q  <= grant_idx;
                        rr_ptr_q <= IDW'(wrap_inc(int'(grant_idx), NREQ));
                        if (grant_last) begin
                            range_q <= '0;
                        end else begin
                            cnt_q  <= CW'(1);
                            hold_q <= req_data[grant_idx];
                        end
                    end
                end
                RUN: begin
                    err_q <= err_q | rf_error;
                    if (cur_valid) begin
                        cnt_q  <= cnt_q + CW'(1);
                        hold_q <= cur_data;
                        if (finish_hit) begin
                            range_q <= rf_range;
                            if (!cur_last) begin
                                trunc_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    err_q <= err_q | rf_error;
                end
                WRAP: begin
                    trunc_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (state_q == WRAP) begin
            res_valid_q <= 1'b1;
            res_q       <= '{range: range_q, id: owner_q, trunc: trunc_q, err: err_q | rf_error};
        end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_range = res_q.range;
    assign res_id    = res_q.id;
    assign res_trunc = res_q.trunc;
    assign res_err   = res_q.err;

    // A waiting result must stay put until it is taken.
    assert property (@(posedge clock) disable iff (reset)
        res_valid && !res_ready |=> res_valid && $stable(res_range) && $stable(res_id));
    assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));

endmodule

// File: tb/tb_range_session_ctrl.sv
// Cycle-exact directed bench for range_session_ctrl with a behavioural
// min/max datapath stub wired to the rf_* pins.
module tb_range_session_ctrl;

    logic             clock;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][9:0]  req_data;
    logic [1:0]       req_last;
    logic [1:0]       req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [9:0]       res_range;
    logic [0:0]       res_id;
    logic             res_trunc;
    logic             res_err;
    logic [9:0]       rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [9:0]       rf_range;
    logic             rf_error;

    int checks;
    int passed;

    range_session_ctrl #(.W(10), .NREQ(2), .MAX_LEN(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_range (res_range),
        .res_id    (res_id),
        .res_trunc (res_trunc),
        .res_err   (res_err),
        .rf_data   (rf_data),
        .rf_go     (rf_go),
        .rf_finish (rf_finish),
        .rf_range  (rf_range),
        .rf_error  (rf_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath stub: range is combinational over the samples seen so far plus the current one.
    logic       dp_going;
    logic [9:0] dp_min, dp_max, dp_lo, dp_hi;

    always_comb begin
        dp_lo    = (rf_data < dp_min) ? rf_data : dp_min;
        dp_hi    = (rf_data > dp_max) ? rf_data : dp_max;
        rf_range = dp_going ? (dp_hi - dp_lo) : 10'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dp_going <= 1'b0;
            dp_min   <= '0;
            dp_max   <= '0;
        end else if (rf_go) begin
            dp_going <= 1'b1;
            dp_min   <= rf_data;
            dp_max   <= rf_data;
        end else if (dp_going) begin
            dp_min <= dp_lo;
            dp_max <= dp_hi;
            if (rf_finish) dp_going <= 1'b0;
        end
    end

    typedef struct {
        logic [1:0] vld;
        logic [1:0] lst;
        logic [9:0] d0;
        logic [9:0] d1;
        logic       rr;
        logic       ein;
        logic [1:0] rdy;
        logic       go;
        logic       fin;
        logic [9:0] rfd;
        logic       rv;
        logic [9:0] rng;
        logic       id;
        logic       tr;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t make_vec(input int vld, input int lst, input int d0, input int d1,
                                      input int rr, input int ein, input int rdy, input int go,
                                      input int fin, input int rfd, input int rv, input int rng,
                                      input int id, input int tr, input int er);
        vec_t v;
        v.vld = 2'(vld);  v.lst = 2'(lst);  v.d0 = 10'(d0);  v.d1 = 10'(d1);
        v.rr  = 1'(rr);   v.ein = 1'(ein);  v.rdy = 2'(rdy); v.go = 1'(go);
        v.fin = 1'(fin);  v.rfd = 10'(rfd); v.rv = 1'(rv);   v.rng = 10'(rng);
        v.id  = 1'(id);   v.tr = 1'(tr);    v.er = 1'(er);
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        req_valid   = v.vld;
        req_last    = v.lst;
        req_data[0] = v.d0;
        req_data[1] = v.d1;
        res_ready   = v.rr;
        rf_error    = v.ein;
        #2;
    endtask

    task automatic check_output(input string name, input vec_t v);
        logic [27:0] act, exp;
        act = {req_ready, rf_go, rf_finish, rf_data, res_valid, res_range, res_id, res_trunc, res_err};
        exp = {v.rdy, v.go, v.fin, v.rfd, v.rv, v.rng, v.id, v.tr, v.er};
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got rdy=%b go=%b fin=%b rfd=%0d rv=%b rng=%0d id=%0d tr=%b er=%b; want rdy=%b go=%b fin=%b rfd=%0d rv=%b rng=%0d id=%0d tr=%b er=%b",
                     name, req_ready, rf_go, rf_finish, rf_data, res_valid, res_range, res_id, res_trunc, res_err,
                     v.rdy, v.go, v.fin, v.rfd, v.rv, v.rng, v.id, v.tr, v.er);
        end else begin
            passed++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        passed    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        res_ready = 1'b0;
        rf_error  = 1'b0;

        //                     vld lst d0  d1 rr ein  rdy go fin rfd  rv rng id tr er
        // req0 burst 5,9,2,7 (last on the MAX_LEN-th beat is a normal finish)
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  0,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(1, 0,  5,  0, 1, 0,   1, 1, 0,  5,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(1, 0,  9,  0, 1, 0,   1, 0, 0,  9,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(1, 0,  2,  0, 1, 0,   1, 0, 0,  2,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(1, 1,  7,  0, 1, 0,   1, 0, 1,  7,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  7,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  7,  1,  7, 0, 0, 0));
        // req1 burst 4,_,_,10 with bubbles
        vecs.push_back(make_vec(2, 0,  0,  4, 1, 0,   2, 1, 0,  4,  0,  7, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   2, 0, 0,  4,  0,  7, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   2, 0, 0,  4,  0,  7, 0, 0, 0));
        vecs.push_back(make_vec(2, 2,  0, 10, 1, 0,   2, 0, 1, 10,  0,  7, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0, 10,  0,  7, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0, 10,  1,  6, 1, 0, 0));
        // both requesters valid, 3-beat bursts, grants 0,1,0,1
        vecs.push_back(make_vec(3, 0,  1, 10, 1, 0,   1, 1, 0,  1,  0,  6, 1, 0, 0));
        vecs.push_back(make_vec(3, 0,  2, 10, 1, 0,   1, 0, 0,  2,  0,  6, 1, 0, 0));
        vecs.push_back(make_vec(3, 1,  3, 10, 1, 0,   1, 0, 1,  3,  0,  6, 1, 0, 0));
        vecs.push_back(make_vec(3, 0,  1, 10, 1, 0,   0, 0, 0,  3,  0,  6, 1, 0, 0));
        vecs.push_back(make_vec(3, 0,  1, 10, 1, 0,   2, 1, 0, 10,  1,  2, 0, 0, 0));
        vecs.push_back(make_vec(3, 0,  1, 20, 1, 0,   2, 0, 0, 20,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(3, 2,  1, 15, 1, 0,   2, 0, 1, 15,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(3, 0,  1, 10, 1, 0,   0, 0, 0, 15,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(3, 0,  1, 10, 1, 0,   1, 1, 0,  1,  1, 10, 1, 0, 0));
        vecs.push_back(make_vec(3, 0,  2, 10, 1, 0,   1, 0, 0,  2,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(3, 1,  3, 10, 1, 0,   1, 0, 1,  3,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(2, 0,  0, 10, 1, 0,   0, 0, 0,  3,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(2, 0,  0, 10, 1, 0,   2, 1, 0, 10,  1,  2, 0, 0, 0));
        vecs.push_back(make_vec(2, 0,  0, 20, 1, 0,   2, 0, 0, 20,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(2, 2,  0, 15, 1, 0,   2, 0, 1, 15,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0, 15,  0,  2, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0, 15,  1, 10, 1, 0, 0));
        // req0 6-beat burst truncated at 4, datapath error during drain
        vecs.push_back(make_vec(1, 0,  3,  0, 1, 0,   1, 1, 0,  3,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(1, 0,  8,  0, 1, 0,   1, 0, 0,  8,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(1, 0,  1,  0, 1, 0,   1, 0, 0,  1,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(1, 0,  6,  0, 1, 0,   1, 0, 1,  6,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(1, 0, 20,  0, 1, 1,   1, 0, 0,  6,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(1, 1,  0,  0, 1, 0,   1, 0, 0,  6,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  6,  0, 10, 1, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  6,  1,  7, 0, 1, 1));
        // single-beat burst 8 from req0 (req1 idle is skipped), result held 3 cycles
        vecs.push_back(make_vec(1, 1,  8,  0, 0, 0,   1, 0, 0,  6,  0,  7, 0, 1, 1));
        vecs.push_back(make_vec(0, 0,  0,  0, 0, 0,   0, 0, 0,  6,  0,  7, 0, 1, 1));
        vecs.push_back(make_vec(2, 0,  0,  5, 0, 0,   0, 0, 0,  6,  1,  0, 0, 0, 0));
        vecs.push_back(make_vec(2, 0,  0,  5, 0, 0,   0, 0, 0,  6,  1,  0, 0, 0, 0));
        vecs.push_back(make_vec(2, 0,  0,  5, 0, 0,   0, 0, 0,  6,  1,  0, 0, 0, 0));
        vecs.push_back(make_vec(2, 0,  0,  5, 1, 0,   2, 1, 0,  5,  1,  0, 0, 0, 0));
        vecs.push_back(make_vec(2, 2,  0,  7, 1, 0,   2, 0, 1,  7,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  7,  0,  0, 0, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  7,  1,  2, 1, 0, 0));
        vecs.push_back(make_vec(0, 0,  0,  0, 1, 0,   0, 0, 0,  7,  0,  2, 1, 0, 0));

        repeat (2) @(negedge clock);
        #2;
        check_output("reset_state", make_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i]);
        end

        // reset in the middle of a RUN session, then a fresh 3,1 burst
        apply_stimulus(make_vec(1, 0, 5, 0, 1, 0, 1, 1, 0, 5, 0, 2, 1, 0, 0));
        check_output("mid_go", make_vec(1, 0, 5, 0, 1, 0, 1, 1, 0, 5, 0, 2, 1, 0, 0));
        apply_stimulus(make_vec(1, 0, 9, 0, 1, 0, 1, 0, 0, 9, 0, 2, 1, 0, 0));
        check_output("mid_run", make_vec(1, 0, 9, 0, 1, 0, 1, 0, 0, 9, 0, 2, 1, 0, 0));
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        @(negedge clock);
        reset = 1'b0;
        #2;
        check_output("after_reset", make_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply_stimulus(make_vec(1, 0, 3, 0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0));
        check_output("restart_go", make_vec(1, 0, 3, 0, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0));
        apply_stimulus(make_vec(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        check_output("restart_fin", make_vec(1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        apply_stimulus(make_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        check_output("restart_wrap", make_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        apply_stimulus(make_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        check_output("restart_res", make_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
